sar_adc_ctrl: RTL
=================

SAR_ADC_CTRL -- requirements
Module: sar_adc_ctrl

Interface
REQ-001 SHALL have parameter SAMPLE_CYCLES, default 2, track/hold acquisition length in clocks (legal 1..15).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 1, DAC settle time per bit trial in clocks (legal 1..15).
REQ-003 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port soc  input  1  start-of-conversion request from consumer.
REQ-006 SHALL have port eoc  output  1  end-of-conversion; 1 = idle/result valid, 0 = converting.
REQ-007 SHALL have port x7_x0  output  8  conversion result, stable whenever eoc=1.
REQ-008 SHALL have port cmp  input  1  analog comparator; 1 = Vin >= DAC voltage.
REQ-009 SHALL have port dac  output  8  code driven to the trial DAC.
REQ-010 SHALL have port sample_hold  output  1  1 = track/hold in track mode.

Function
REQ-011 SHALL implement states IDLE, SAMPLE, TRIAL, WAIT_SOC_LOW.
REQ-012 IDLE: eoc=1, sample_hold=0; on an edge with soc=1, SHALL go to SAMPLE, eoc<=0, sample_hold<=1, dac<=0x00, result<=0x00, bit pointer<=7.
REQ-013 SAMPLE SHALL last exactly SAMPLE_CYCLES clocks, then go to TRIAL with sample_hold<=0 and dac<=0x80.
REQ-014 TRIAL SHALL drive dac = result | (1<<bit) for SETTLE_CYCLES clocks; cmp SHALL be sampled only at the edge ending the last settle clock.
REQ-015 At that edge: cmp=1 -> result[bit]<=1, cmp=0 -> result[bit]<=0; bit>0 -> bit<=bit-1 and dac<=new result | (1<<(bit-1)); bit=0 -> go to WAIT_SOC_LOW with dac<=final result.
REQ-016 WAIT_SOC_LOW: on an edge with soc=0, SHALL load x7_x0<=result and eoc<=1 on that same edge, go to IDLE; while soc=1, SHALL hold eoc=0 (four-phase handshake).
REQ-017 Latency: if soc is already 0, eoc SHALL rise at edge N+SAMPLE_CYCLES+8*SETTLE_CYCLES+1, where N = edge sampling soc=1 (defaults: N+11).
REQ-018 x7_x0 SHALL change only on the eoc 0->1 edge; it SHALL keep the previous result during a conversion.
REQ-019 soc changes outside IDLE/WAIT_SOC_LOW SHALL be ignored; no restart mid-conversion.
REQ-020 soc held 1 continuously SHALL give back-to-back conversions only after the mandatory soc=0 phase; eoc=1 in IDLE with soc=1 SHALL start a new conversion on the next edge.
REQ-021 cmp SHALL be ignored in IDLE, SAMPLE, WAIT_SOC_LOW and on non-final settle clocks.
REQ-022 Settle/sample counter SHALL be 4 bits and reload per phase; no wrap into adjacent phases.

Reset
REQ-023 With reset=1 at an edge: state<=IDLE, eoc<=1, x7_x0<=0x00, dac<=0x00, sample_hold<=0, counters and bit pointer cleared.
REQ-024 Reset SHALL take priority over all transitions and abort any conversion in progress, discarding the partial result.
REQ-025 First conversion SHALL be accepted on the first edge after reset deassertion with soc=1.

Verification
REQ-026 Comparator model cmp=(dac<=0xA5), defaults, soc pulse 1 clock -> eoc low next edge, high 11 edges after start, x7_x0=0xA5.
REQ-027 Vin=0x00 and Vin=0xFF -> x7_x0=0x00 and 0xFF; dac trial sequence for 0xFF = 80,C0,E0,F0,F8,FC,FE,FF.
REQ-028 soc held high 5 clocks past conversion end -> eoc stays 0 until edge after soc falls, then eoc=1 with x7_x0 valid same edge.
REQ-029 reset pulsed at bit 4 trial of a 0x5A conversion -> next edge eoc=1, x7_x0=0x00, dac=0x00, sample_hold=0.
REQ-030 SAMPLE_CYCLES=3, SETTLE_CYCLES=2, Vin=0x3C -> sample_hold high 3 clocks, each dac code held 2 clocks, eoc rises N+20, x7_x0=0x3C.
REQ-031 soc toggled during TRIAL -> no effect on sequence or result.

Source files
------------

// File: rtl/sar_adc_ctrl_if.sv
// Handshake and analog-side signals of the SAR ADC controller.
// The slave modport is the controller; the master modport is the consumer plus analog front end.
interface sar_adc_ctrl_if;
  logic       soc;
  logic       cmp;
  logic       eoc;
  logic [7:0] x7_x0;
  logic [7:0] dac;
  logic       sample_hold;

  modport slave (
    input  soc,
    input  cmp,
    output eoc,
    output x7_x0,
    output dac,
    output sample_hold
  );

  modport master (
    output soc,
    output cmp,
    input  eoc,
    input  x7_x0,
    input  dac,
    input  sample_hold
  );
endinterface

// File: rtl/sar_adc_ctrl.sv
// 8-bit successive-approximation ADC controller with a four-phase soc/eoc handshake.
// All outputs are registered; cmp is sampled only on the last settle clock of each bit trial.
module sar_adc_ctrl #(
  parameter int SAMPLE_CYCLES = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic          clock,
  input  logic          reset,
  sar_adc_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    SAMPLE       = 2'd1,
    TRIAL        = 2'd2,
    WAIT_SOC_LOW = 2'd3
  } state_t;

  localparam logic [3:0] SAMPLE_LOAD = 4'(SAMPLE_CYCLES - 1);
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [2:0] r_bit;
  logic [7:0] r_result;
  logic [7:0] r_dac;
  logic [7:0] r_x7_x0;
  logic       r_eoc;
  logic       r_sample_hold;

  state_t     w_state;
  logic [3:0] w_cnt;
  logic [2:0] w_bit;
  logic [7:0] w_result;
  logic [7:0] w_dac;
  logic [7:0] w_x7_x0;
  logic       w_eoc;
  logic       w_sample_hold;
  logic [7:0] w_mask;
  logic [7:0] w_next_mask;
  logic [7:0] w_decided;

  // State and output registers; reset aborts any conversion in progress
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= IDLE;
      r_cnt         <= 4'd0;
      r_bit         <= 3'd0;
      r_result      <= 8'h00;
      r_dac         <= 8'h00;
      r_x7_x0       <= 8'h00;
      r_eoc         <= 1'b1;
      r_sample_hold <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_cnt         <= w_cnt;
      r_bit         <= w_bit;
      r_result      <= w_result;
      r_dac         <= w_dac;
      r_x7_x0       <= w_x7_x0;
      r_eoc         <= w_eoc;
      r_sample_hold <= w_sample_hold;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state       = r_state;
    w_cnt         = r_cnt;
    w_bit         = r_bit;
    w_result      = r_result;
    w_dac         = r_dac;
    w_x7_x0       = r_x7_x0;
    w_eoc         = r_eoc;
    w_sample_hold = r_sample_hold;
    w_mask        = 8'd1 << r_bit;
    w_next_mask   = 8'd1 << (r_bit - 3'd1);
    w_decided     = bus.cmp ? (r_result | w_mask) : (r_result & ~w_mask);

    case (r_state)
      IDLE: begin
        if (bus.soc) begin
          w_state       = SAMPLE;
          w_eoc         = 1'b0;
          w_sample_hold = 1'b1;
          w_dac         = 8'h00;
          w_result      = 8'h00;
          w_bit         = 3'd7;
          w_cnt         = SAMPLE_LOAD;
        end else begin
          w_state = IDLE;
        end
      end
      SAMPLE: begin
        if (r_cnt == 4'd0) begin
          w_state       = TRIAL;
          w_sample_hold = 1'b0;
          w_dac         = 8'h80;
          w_cnt         = SETTLE_LOAD;
        end else begin
          w_cnt = r_cnt - 4'd1;
        end
      end
      TRIAL: begin
        // Only the edge that ends the last settle clock commits a bit decision
        if (r_cnt == 4'd0) begin
          w_result = w_decided;
          if (r_bit != 3'd0) begin
            w_bit = r_bit - 3'd1;
            w_dac = w_decided | w_next_mask;
            w_cnt = SETTLE_LOAD;
          end else begin
            w_state = WAIT_SOC_LOW;
            w_dac   = w_decided;
          end
        end else begin
          w_cnt = r_cnt - 4'd1;
        end
      end
      WAIT_SOC_LOW: begin
        if (!bus.soc) begin
          w_state = IDLE;
          w_x7_x0 = r_result;
          w_eoc   = 1'b1;
        end else begin
          w_state = WAIT_SOC_LOW;
        end
      end
      default: begin
        w_state       = IDLE;
        w_eoc         = 1'b1;
        w_sample_hold = 1'b0;
      end
    endcase
  end

  assign bus.eoc         = r_eoc;
  assign bus.x7_x0       = r_x7_x0;
  assign bus.dac         = r_dac;
  assign bus.sample_hold = r_sample_hold;

endmodule
